// File: rtl/int2flt32_if.sv
// rtl/int2flt32_if.sv - operand/result bundle for the int-to-binary32 converter
// Ports (as seen by the converter, slave modport):
//   ce        in   pipeline advance enable, 0 holds every stage
//   in_valid  in   a carries an operand this cycle
//   a         in   signed 32-bit integer operand
//   out_valid out  z holds a result
//   z         out  binary32 result {sign, exp[7:0], frac[22:0]}
interface int2flt32_if;
  logic        ce;
  logic        in_valid;
  logic [31:0] a;
  logic        out_valid;
  logic [31:0] z;

  modport master (output ce, output in_valid, output a, input out_valid, input z);
  modport slave  (input ce, input in_valid, input a, output out_valid, output z);
endinterface

// File: rtl/int2flt32.sv
// rtl/int2flt32.sv - 3-stage signed int32 to binary32 converter, round-to-nearest-even
// Ports:
//   clk  in   clock, all state updates on the rising edge
//   rst  in   synchronous reset, active-high, overrides ce
//   bus  slave modport of int2flt32_if (ce, in_valid, a, out_valid, z)
module int2flt32 (
  input  logic        clk,
  input  logic        rst,
  int2flt32_if.slave  bus
);

  // Stage 1: sign / magnitude
  logic        v1;
  logic        s1_s;
  logic [31:0] s1_m;
  logic        s1_zero;

  // Stage 2: normalised magnitude and biased exponent
  logic        v2;
  logic        s2_s;
  logic [31:0] s2_n;
  logic [8:0]  s2_e;
  logic        s2_zero;

  // Stage 3: packed result
  logic        out_valid_q;
  logic [31:0] z_q;

  // Leading-zero count of the stage-1 magnitude. A zero magnitude yields 0;
  // the zero flag forces the packed result to 0 in that case anyway.
  logic [4:0]  lz;
  logic        lz_found;

  always_comb begin
    lz       = 5'd0;
    lz_found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!lz_found && s1_m[i]) begin
        lz       = 5'(31 - i);
        lz_found = 1'b1;
      end
    end
  end

  // Round/pack. The hidden bit sits at s2_n[31]; bits below the 24 kept
  // bits form guard (bit 7) and sticky (bits 6:0).
  logic [23:0] mant;
  logic        guard;
  logic        sticky;
  logic        lsb;
  logic        roundup;
  logic [24:0] mant_r;
  logic [8:0]  e_r;
  logic [22:0] frac;
  logic [31:0] z_next;

  always_comb begin
    mant    = s2_n[31:8];
    guard   = s2_n[7];
    sticky  = |s2_n[6:0];
    lsb     = s2_n[8];
    roundup = guard & (sticky | lsb);
    mant_r  = {1'b0, mant} + {24'd0, roundup};
    // A carry out of the mantissa means it rounded up to exactly 2.0 x 2^e:
    // bump the exponent and clear the fraction. Exponent tops out at 158.
    e_r     = s2_e + {8'd0, mant_r[24]};
    frac    = mant_r[24] ? 23'd0 : mant_r[22:0];
    z_next  = s2_zero ? 32'h0 : {s2_s, e_r[7:0], frac};
  end

  // e_r[8] can never be set and mant_r[23] is the implicit bit.
  logic unused_bits;
  assign unused_bits = ^{e_r[8], mant_r[23]};

  always_ff @(posedge clk) begin
    if (rst) begin
      v1          <= 1'b0;
      s1_s        <= 1'b0;
      s1_m        <= 32'd0;
      s1_zero     <= 1'b0;
      v2          <= 1'b0;
      s2_s        <= 1'b0;
      s2_n        <= 32'd0;
      s2_e        <= 9'd0;
      s2_zero     <= 1'b0;
      out_valid_q <= 1'b0;
      z_q         <= 32'h0;
    end else if (bus.ce) begin
      // Bubbles advance the data registers too; only the valid bits matter.
      v1          <= bus.in_valid;
      s1_s        <= bus.a[31];
      // -0x80000000 wraps to 0x80000000, which is the correct magnitude.
      s1_m        <= bus.a[31] ? (~bus.a + 32'd1) : bus.a;
      s1_zero     <= (bus.a == 32'd0);

      v2          <= v1;
      s2_s        <= s1_s;
      s2_n        <= s1_m << lz;
      s2_e        <= 9'd158 - {4'd0, lz};
      s2_zero     <= s1_zero;

      out_valid_q <= v2;
      z_q         <= z_next;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.z         = z_q;

endmodule

// File: tb/tb_int2flt32.sv
// tb/tb_int2flt32.sv - self-checking bench for int2flt32
module tb_int2flt32;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  int2flt32_if bus ();

  int2flt32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Reference conversion: exact magnitude, locate top bit, round the value
  // to 24 significant bits with ties going to the even neighbour.
  function automatic logic [31:0] ref_cvt(input logic [31:0] x);
    longint m, q, rem, half;
    int     p, sh;
    logic   s;
    if (x == 32'd0) return 32'h0;
    s = x[31];
    m = longint'({32'd0, x});
    if (s) m = 64'd4294967296 - m;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    if (p > 23) begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        p++;
      end
    end else begin
      q = m << (23 - p);
    end
    return {s, 8'(127 + p), q[22:0]};
  endfunction

  // Scoreboard: valid timing by counting ce-active edges, values in a queue.
  logic [2:0]  vpipe = 3'b000;
  logic [31:0] expq[$];
  logic        started = 1'b0;
  logic        fresh   = 1'b0;
  logic        rst_hit = 1'b0;
  logic        prev_v;
  logic [31:0] prev_z;

  always @(posedge clk) begin
    started = 1'b1;
    rst_hit = 1'b0;
    if (rst) begin
      vpipe   = 3'b000;
      expq.delete();
      fresh   = 1'b1;
      rst_hit = 1'b1;
    end else if (bus.ce) begin
      vpipe = {vpipe[1:0], bus.in_valid};
      if (bus.in_valid) expq.push_back(ref_cvt(bus.a));
      fresh = 1'b1;
    end else begin
      fresh = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, vpipe[2]});
      if (rst_hit) begin
        check("z_after_reset", bus.z, 32'h0);
      end else if (!fresh) begin
        check("stall_hold_valid", {31'd0, bus.out_valid}, {31'd0, prev_v});
        check("stall_hold_z", bus.z, prev_z);
      end else if (vpipe[2]) begin
        if (expq.size() == 0) begin
          check("result_expected", 32'd0, 32'd1);
        end else begin
          check("z", bus.z, expq.pop_front());
        end
      end
      prev_v = bus.out_valid;
      prev_z = bus.z;
    end
  end

  task automatic step(input logic r, input logic c, input logic v, input logic [31:0] d);
    rst          = r;
    bus.ce       = c;
    bus.in_valid = v;
    bus.a        = d;
    @(negedge clk);
  endtask

  logic [31:0] vec_a [10] = '{32'd1, 32'hFFFFFFFF, 32'd0, 32'h80000000, 32'h7FFFFFFF,
                              32'h00FFFFFF, 32'h01000001, 32'h01000003, 32'h01000005,
                              32'hFEFFFFFD};
  logic [31:0] vec_z [10] = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'hCF000000,
                              32'h4F000000, 32'h4B7FFFFF, 32'h4B800000, 32'h4B800002,
                              32'h4B800002, 32'hCB800002};

  initial begin
    // Pin the reference against hand-computed values.
    for (int i = 0; i < 10; i++) check("ref_literal", ref_cvt(vec_a[i]), vec_z[i]);

    // Reset with ce low must still clear everything.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h12345678);
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_z", bus.z, 32'h0);

    // Basic/extreme/rounding vectors back-to-back, then drain.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, vec_a[i]);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("latency_first_after_drain_gap", {31'd0, bus.out_valid}, 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);

    // Stall: 3 operands in flight, ce low for 4 cycles with noise on inputs.
    step(1'b0, 1'b1, 1'b1, 32'd100);
    step(1'b0, 1'b1, 1'b1, 32'hFFFFFF9C);
    step(1'b0, 1'b1, 1'b1, 32'h01000003);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, i[0], 32'hA5A5A5A5 ^ i);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'h0);

    // Reset mid-flight: 2 operands issued, then a 1-cycle reset.
    step(1'b0, 1'b1, 1'b1, 32'd7);
    step(1'b0, 1'b1, 1'b1, 32'd9);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("midreset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midreset_z", bus.z, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'd3);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("post_reset_latency_valid", {31'd0, bus.out_valid}, 32'd1);
    check("post_reset_latency_z", bus.z, 32'h40400000);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);

    // Random stream with random ce/in_valid.
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] r;
      r = $urandom();
      case ($urandom_range(0, 7))
        0: r = r >> $urandom_range(0, 31);
        1: r = -(r >> $urandom_range(0, 31));
        default: ;
      endcase
      step(1'b0, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, r);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    check("queue_drained", expq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
